// File: rtl/mux_pipe_pkg.sv
// Shared types and elaboration helpers for the round-robin merge pipe.
package mux_pipe_pkg;

   localparam int MAX_NCHAN = 8;

   // Wide enough to name any channel up to MAX_NCHAN.
   typedef logic [2:0] chan_idx_t;

   // Ceiling log2, never less than 1 so it can size a vector directly.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) bits++;
      return (bits < 1) ? 1 : bits;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_nbuf.sv
// DEPTH-entry FIFO for one forward channel; head is visible the cycle after enqueue.
module fifo_nbuf
   import mux_pipe_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int DEPTH = 2
) (
   input  logic                     clk_sys,
   input  logic                     rst_b,
   input  logic                     enq,
   input  logic [WIDTH-1:0]         enq_data,
   input  logic                     deq,
   output logic [WIDTH-1:0]         first,
   output logic [clog2(DEPTH):0]    count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_enq, do_deq;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign first = mem_q[rd_ptr_q];

   // Pointer and occupancy update; power-of-2 depth lets pointers wrap naturally.
   always_comb begin
      do_enq   = enq & ~full;
      do_deq   = deq & ~empty;
      wr_ptr_d = wr_ptr_q + PW'(do_enq);
      rd_ptr_d = rd_ptr_q + PW'(do_deq);
      count_d  = count_q + CW'(do_enq) - CW'(do_deq);
   end

   // Storage is not reset: clearing the count is what discards the contents.
   always_ff @(posedge clk_sys) begin
      if (do_enq) mem_q[wr_ptr_q] <= enq_data;
   end

   // Pointer/count registers with synchronous clear.
   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mux_pipe_rr.sv
// Merges NCHAN buffered forward streams (round-robin) and one direct stream
// (lowest priority, with a periodic guaranteed slot) onto one output.
module mux_pipe_rr
   import mux_pipe_pkg::*;
#(
   parameter int WIDTH   = 128,
   parameter int NCHAN   = 2,
   parameter int DEPTH   = 2,
   parameter int IN_SLOT = 4
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   in_enq_ena,
   input  logic [WIDTH-1:0]       in_enq_v,
   output logic                   in_enq_rdy,
   input  logic [NCHAN-1:0]       forward_enq_ena,
   input  logic [NCHAN*WIDTH-1:0] forward_enq_v,
   output logic [NCHAN-1:0]       forward_enq_rdy,
   output logic                   out_enq_ena,
   output logic [WIDTH-1:0]       out_enq_v,
   input  logic                   out_enq_rdy
);

   localparam bit CFG_OK = is_pow2(DEPTH) && (NCHAN >= 1) && (NCHAN <= MAX_NCHAN) && (WIDTH >= 1);
   localparam int SLOT_W = clog2(IN_SLOT + 1);
   localparam logic [SLOT_W-1:0] SLOT_RELOAD = SLOT_W'(IN_SLOT);

   if (!CFG_OK) begin : g_cfg_err
      $error("mux_pipe_rr: DEPTH must be a power of 2 (>=2) and NCHAN in 1..8");
   end

   // Slot timer counts down the FIFO transfers left before the direct slot.
   logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
   chan_idx_t         last_q, last_d;

   logic [WIDTH-1:0]     fifo_first [NCHAN];
   logic [clog2(DEPTH):0] fifo_count [NCHAN];
   logic [NCHAN-1:0]     fifo_full, fifo_empty, fifo_req, fifo_enq, fifo_deq;

   logic      slot_turn, fgrant_valid, fifo_xfer, direct_xfer;
   chan_idx_t grant_idx;
   logic [3:0] pick;

   // Returns {valid, index} of the first requester after 'last', circularly.
   function automatic logic [3:0] rr_pick(input logic [NCHAN-1:0] req, input chan_idx_t last);
      logic [NCHAN-1:0] rot;
      int               idx;
      rr_pick = '0;
      for (int i = NCHAN; i >= 1; i--) begin
         idx = (int'(last) + i) % NCHAN;
         rot = req >> idx;
         if (rot[0]) rr_pick = {1'b1, chan_idx_t'(idx)};
      end
   endfunction

   for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      assign forward_enq_rdy[c] = nRST & ~fifo_full[c];
      assign fifo_enq[c]        = forward_enq_ena[c] & forward_enq_rdy[c];
      assign fifo_req[c]        = (fifo_count[c] != '0);

      fifo_nbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk_sys  (CLK),
         .rst_b    (nRST),
         .enq      (fifo_enq[c]),
         .enq_data (forward_enq_v[c*WIDTH +: WIDTH]),
         .deq      (fifo_deq[c]),
         .first    (fifo_first[c]),
         .count    (fifo_count[c]),
         .full     (fifo_full[c]),
         .empty    (fifo_empty[c])
      );
   end

   // Arbitration, output mux and next-state for slot timer and RR pointer.
   always_comb begin
      slot_turn    = (IN_SLOT != 0) && (slot_cnt_q == '0);
      pick         = rr_pick(fifo_req, last_q);
      grant_idx    = pick[2:0];
      fgrant_valid = nRST & pick[3] & ~slot_turn;
      in_enq_rdy   = nRST & out_enq_rdy & ~fgrant_valid;
      fifo_xfer    = fgrant_valid & out_enq_rdy;
      direct_xfer  = in_enq_ena & in_enq_rdy;
      out_enq_ena  = fifo_xfer | direct_xfer;

      out_enq_v = in_enq_v;
      fifo_deq  = '0;
      for (int c = 0; c < NCHAN; c++) begin
         if (fgrant_valid && (chan_idx_t'(c) == grant_idx)) out_enq_v = fifo_first[c];
         fifo_deq[c] = fifo_xfer && (chan_idx_t'(c) == grant_idx) && !fifo_empty[c];
      end

      slot_cnt_d = slot_cnt_q;
      if (slot_turn || direct_xfer)            slot_cnt_d = SLOT_RELOAD;
      else if (fifo_xfer && slot_cnt_q != '0) slot_cnt_d = slot_cnt_q - 1'b1;

      last_d = fifo_xfer ? grant_idx : last_q;
   end

   // Arbiter state; reset points 'last' at the top channel so channel 0 goes first.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         slot_cnt_q <= SLOT_RELOAD;
         last_q     <= chan_idx_t'(NCHAN - 1);
      end else begin
         slot_cnt_q <= slot_cnt_d;
         last_q     <= last_d;
      end
   end

endmodule

// File: tb/tb_mux_pipe_rr.sv
module tb_mux_pipe_rr;

   localparam int WIDTH   = 16;
   localparam int NCHAN   = 2;
   localparam int DEPTH   = 2;
   localparam int IN_SLOT = 4;

   logic                   CLK = 1'b0;
   logic                   nRST;
   logic                   in_enq_ena;
   logic [WIDTH-1:0]       in_enq_v;
   logic                   in_enq_rdy;
   logic [NCHAN-1:0]       forward_enq_ena;
   logic [NCHAN*WIDTH-1:0] forward_enq_v;
   logic [NCHAN-1:0]       forward_enq_rdy;
   logic                   out_enq_ena;
   logic [WIDTH-1:0]       out_enq_v;
   logic                   out_enq_rdy;

   mux_pipe_rr #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH), .IN_SLOT(IN_SLOT)) dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .in_enq_ena      (in_enq_ena),
      .in_enq_v        (in_enq_v),
      .in_enq_rdy      (in_enq_rdy),
      .forward_enq_ena (forward_enq_ena),
      .forward_enq_v   (forward_enq_v),
      .forward_enq_rdy (forward_enq_rdy),
      .out_enq_ena     (out_enq_ena),
      .out_enq_v       (out_enq_v),
      .out_enq_rdy     (out_enq_rdy)
   );

   always #5 CLK = ~CLK;

   // Reference model: per-channel queues, last-served channel, transfers since slot.
   logic [WIDTH-1:0] mq [NCHAN][$];
   logic [WIDTH-1:0] expq [$];
   int               m_last = NCHAN - 1;
   int               m_slot = 0;
   int               checks = 0;
   int               errors = 0;
   bit               done   = 0;

   task automatic step(input bit rst_n, input logic [NCHAN-1:0] fena_req,
                       input logic [NCHAN*WIDTH-1:0] fdata, input bit iena_req,
                       input logic [WIDTH-1:0] idata, input bit ordy);
      int               g;
      bit               turn;
      bit               m_in_rdy;
      logic [NCHAN-1:0] m_fwd_rdy;
      @(negedge CLK);
      g    = -1;
      turn = rst_n && (IN_SLOT != 0) && (m_slot == IN_SLOT);
      if (rst_n && !turn) begin
         for (int i = 1; i <= NCHAN; i++) begin
            int c;
            c = (m_last + i) % NCHAN;
            if (g < 0 && mq[c].size() > 0) g = c;
         end
      end
      m_in_rdy = rst_n && ordy && (g < 0);
      for (int c = 0; c < NCHAN; c++) m_fwd_rdy[c] = rst_n && (mq[c].size() < DEPTH);

      nRST            = rst_n;
      out_enq_rdy     = ordy;
      forward_enq_ena = fena_req & m_fwd_rdy;
      forward_enq_v   = fdata;
      in_enq_ena      = iena_req & m_in_rdy;
      in_enq_v        = idata;

      if (rst_n) begin
         if (g >= 0 && ordy) expq.push_back(mq[g][0]);
         else if (in_enq_ena) expq.push_back(idata);
      end

      #1;
      checks++;
      if (in_enq_rdy !== m_in_rdy) begin
         errors++;
         $display("FAIL in_rdy got %b exp %b at %0t", in_enq_rdy, m_in_rdy, $time);
      end
      checks++;
      if (forward_enq_rdy !== m_fwd_rdy) begin
         errors++;
         $display("FAIL fwd_rdy got %b exp %b at %0t", forward_enq_rdy, m_fwd_rdy, $time);
      end

      if (!rst_n) begin
         for (int c = 0; c < NCHAN; c++) mq[c].delete();
         m_last = NCHAN - 1;
         m_slot = 0;
      end else begin
         if (g >= 0 && ordy) begin
            void'(mq[g].pop_front());
            m_last = g;
            if (m_slot < IN_SLOT) m_slot++;
         end
         if (turn || in_enq_ena) m_slot = 0;
         for (int c = 0; c < NCHAN; c++)
            if (forward_enq_ena[c]) mq[c].push_back(fdata[c*WIDTH +: WIDTH]);
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b1, '0, '0, 1'b0, '0, ordy);
   endtask

   // Monitor: every presented output must match the oldest expectation, and no
   // expectation may be left unconsumed within its cycle.
   initial begin
      logic [WIDTH-1:0] e;
      while (!done) begin
         @(negedge CLK);
         #2;
         if (out_enq_ena === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out got %h exp none at %0t", out_enq_v, $time);
            end else begin
               e = expq.pop_front();
               if (out_enq_v !== e) begin
                  errors++;
                  $display("FAIL out_data got %h exp %h at %0t", out_enq_v, e, $time);
               end
            end
         end
         if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_out got ena=%b exp %h at %0t", out_enq_ena, expq[0], $time);
            expq.delete();
         end
      end
   end

   initial begin
      nRST = 1'b0; in_enq_ena = 1'b0; in_enq_v = '0;
      forward_enq_ena = '0; forward_enq_v = '0; out_enq_rdy = 1'b1;

      // Reset held, then idle with consumer ready.
      step(1'b0, 2'b11, '0, 1'b1, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0, '0, 1'b1);
      idle(2, 1'b1);

      // Two channels pushed together: expect A0,B0,A1,B1.
      step(1'b1, 2'b11, {16'hB000, 16'hA000}, 1'b0, '0, 1'b1);
      step(1'b1, 2'b11, {16'hB001, 16'hA001}, 1'b0, '0, 1'b1);
      idle(5, 1'b1);

      // Fill channel 1 with consumer stalled, then release.
      for (int i = 0; i < 3; i++) step(1'b1, 2'b10, {16'hC000 + 16'(i), 16'h0}, 1'b0, '0, 1'b0);
      idle(4, 1'b1);

      // Channel 0 kept busy while the direct input is held: slot must open.
      for (int i = 0; i < 14; i++)
         step(1'b1, 2'b01, {16'h0, 16'hD000 + 16'(i)}, 1'b1, 16'hEE00 + 16'(i), 1'b1);
      idle(4, 1'b1);

      // Direct only with consumer ready toggling.
      step(1'b1, '0, '0, 1'b1, 16'h1111, 1'b1);
      step(1'b1, '0, '0, 1'b1, 16'h2222, 1'b0);
      step(1'b1, '0, '0, 1'b1, 16'h3333, 1'b1);

      // Half fill, pulse reset, nothing stale may emerge.
      step(1'b1, 2'b11, {16'h5501, 16'h5500}, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      idle(4, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0), NCHAN'($urandom), NCHAN*WIDTH'($urandom),
              1'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) != 0));
      end
      idle(6, 1'b1);

      @(negedge CLK);
      #3;
      done = 1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d exp 0", expq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
